// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, SR/Cause field positions,
// exception codes and a small PC helper used when capturing EPC.
package cp0_pkg;

    localparam logic [31:0] HANDLER_ADDR_DEFAULT = 32'h0000_4180;
    localparam int          NUM_HWINT_DEFAULT    = 6;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;

    // SR layout: IM occupies the bits starting at IM_LO, plus EXL and IE.
    localparam int SR_IE_BIT  = 0;
    localparam int SR_EXL_BIT = 1;
    localparam int IM_LO      = 10;

    // Cause layout: BD on top, IP shares IM_LO with SR, ExcCode in [6:2].
    localparam int CAUSE_BD_BIT = 31;
    localparam int CAUSE_EXC_LO = 2;

    typedef enum logic [4:0] {
        EXC_INT     = 5'd0,
        EXC_ADEL    = 5'd4,
        EXC_ADES    = 5'd5,
        EXC_SYSCALL = 5'd8,
        EXC_RI      = 5'd10,
        EXC_OV      = 5'd12
    } exc_code_e;

    // Victim PCs are word addresses; the low two bits are dropped before use.
    function automatic logic [31:0] word_align(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor 0: holds SR, Cause and EPC, raises the flush/redirect request
// for interrupts and exceptions, and services mtc0/mfc0/eret.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEFAULT,
    parameter int          NUM_HWINT    = NUM_HWINT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [4:0]           cp0_addr,
    input  logic [31:0]          cp0_wdata,
    output logic [31:0]          cp0_rdata,
    input  logic [31:0]          vpc,
    input  logic                 bd_in,
    input  logic [4:0]           exc_code_in,
    input  logic                 exl_clr,
    input  logic [NUM_HWINT-1:0] hw_int,
    output logic                 req,
    output logic [31:0]          epc_out,
    output logic [31:0]          handler_pc
);

    logic [NUM_HWINT-1:0] im;
    logic                 exl;
    logic                 ie;
    logic                 cause_bd;
    logic [NUM_HWINT-1:0] ip;
    logic [4:0]           exc_code;
    logic [31:0]          epc;

    logic                 int_req;
    logic                 exc_req;
    logic [31:0]          epc_next;
    logic [31:0]          sr_value;
    logic [31:0]          cause_value;

    // Request logic: interrupts need IE and an unmasked line; both sources
    // are blocked while EXL is set. A delay-slot victim restarts at the branch.
    always_comb begin
        int_req  = ie & ~exl & (|(hw_int & im));
        exc_req  = ~exl & (exc_code_in != 5'd0);
        req      = int_req | exc_req;
        epc_next = bd_in ? (word_align(vpc) - 32'd4) : word_align(vpc);
    end

    // Assemble the architecturally visible SR and Cause words; unused bits read 0.
    always_comb begin
        sr_value                             = '0;
        sr_value[IM_LO +: NUM_HWINT]         = im;
        sr_value[SR_EXL_BIT]                 = exl;
        sr_value[SR_IE_BIT]                  = ie;
        cause_value                          = '0;
        cause_value[CAUSE_BD_BIT]            = cause_bd;
        cause_value[IM_LO +: NUM_HWINT]      = ip;
        cause_value[CAUSE_EXC_LO +: 5]       = exc_code;
    end

    // mfc0 read mux: returns the registered value, never the word being written.
    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            CP0_SR:    cp0_rdata = sr_value;
            CP0_CAUSE: cp0_rdata = cause_value;
            CP0_EPC:   cp0_rdata = epc;
            default:   cp0_rdata = '0;
        endcase
    end

    // Register update: IP tracks the lines every cycle; a request captures the
    // victim and drops any mtc0 in the same cycle; eret clears EXL after a SR write.
    always_ff @(posedge clk) begin
        if (reset) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            cause_bd <= 1'b0;
            ip       <= '0;
            exc_code <= 5'd0;
            epc      <= 32'd0;
        end else begin
            ip <= hw_int;
            if (req) begin
                exl      <= 1'b1;
                cause_bd <= bd_in;
                exc_code <= int_req ? EXC_INT : exc_code_in;
                epc      <= epc_next;
            end else begin
                if (en) begin
                    if (cp0_addr == CP0_SR) begin
                        im  <= cp0_wdata[IM_LO +: NUM_HWINT];
                        exl <= cp0_wdata[SR_EXL_BIT];
                        ie  <= cp0_wdata[SR_IE_BIT];
                    end else if (cp0_addr == CP0_EPC) begin
                        epc <= cp0_wdata;
                    end
                end
                if (exl_clr) begin
                    exl <= 1'b0;
                end
            end
        end
    end

    assign epc_out    = epc;
    assign handler_pc = HANDLER_ADDR;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit: expectations are queued when a step is driven
// and popped in order as DUT outputs are sampled between clock edges.
module tb_cp0_unit;
    import cp0_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic        exl_clr;
    logic [5:0]  hw_int;
    logic        req;
    logic [31:0] epc_out;
    logic [31:0] handler_pc;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    cp0_unit dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .cp0_addr    (cp0_addr),
        .cp0_wdata   (cp0_wdata),
        .cp0_rdata   (cp0_rdata),
        .vpc         (vpc),
        .bd_in       (bd_in),
        .exc_code_in (exc_code_in),
        .exl_clr     (exl_clr),
        .hw_int      (hw_int),
        .req         (req),
        .epc_out     (epc_out),
        .handler_pc  (handler_pc)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic w_en, input logic [4:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] pc,
                                 input logic bd, input logic [4:0] code,
                                 input logic clr, input logic [5:0] lines);
        en          = w_en;
        cp0_addr    = addr;
        cp0_wdata   = wdata;
        vpc         = pc;
        bd_in       = bd;
        exc_code_in = code;
        exl_clr     = clr;
        hw_int      = lines;
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input logic [31:0] observed);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty observed=%h expected=none", observed);
        end else begin
            e = sb.pop_front();
            assert (observed === e.value) else begin
                errors++;
                $error("[TB] FAIL %s observed=%h expected=%h", e.tag, observed, e.value);
            end
        end
    endtask

    task automatic observe_reg(input logic [4:0] addr);
        cp0_addr = addr;
        #1;
        checkOutput(cp0_rdata);
    endtask

    task automatic observe_req;
        checkOutput({31'd0, req});
    endtask

    initial begin
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);
        tick;
        tick;
        reset = 1'b0;
        $display("[TB] reset released");

        expect_val("reset_sr", 32'd0);        observe_reg(CP0_SR);
        expect_val("reset_cause", 32'd0);     observe_reg(CP0_CAUSE);
        expect_val("reset_epc", 32'd0);       observe_reg(CP0_EPC);
        expect_val("reset_req", 32'd0);       observe_req;
        expect_val("handler_pc", 32'h0000_4180); checkOutput(handler_pc);

        // mtc0 SR: no same-cycle bypass, value visible after the edge
        applyStimulus(1'b1, CP0_SR, 32'h0000_0401, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);
        expect_val("sr_no_bypass", 32'd0);    observe_reg(CP0_SR);
        expect_val("sr_written", 32'h0000_0401);
        tick;
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);
        observe_reg(CP0_SR);

        // interrupt on line 0
        applyStimulus(1'b0, 5'd0, 32'd0, 32'h0000_3010, 1'b0, 5'd0, 1'b0, 6'b000001);
        expect_val("int_req", 32'd1);         observe_req;
        expect_val("int_epc", 32'h0000_3010);
        expect_val("int_cause", 32'h0000_0400);
        expect_val("int_sr", 32'h0000_0403);
        expect_val("int_req_masked_exl", 32'd0);
        tick;
        checkOutput(epc_out);
        observe_reg(CP0_CAUSE);
        observe_reg(CP0_SR);
        observe_req;

        // eret: no request in its own cycle, EXL cleared afterwards
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b1, 6'd0);
        expect_val("eret_req", 32'd0);        observe_req;
        expect_val("eret_sr", 32'h0000_0401);
        expect_val("eret_cause", 32'd0);
        tick;
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);
        observe_reg(CP0_SR);
        observe_reg(CP0_CAUSE);

        // overflow in a delay slot
        applyStimulus(1'b0, 5'd0, 32'd0, 32'h0000_3024, 1'b1, EXC_OV, 1'b0, 6'd0);
        expect_val("ov_req", 32'd1);          observe_req;
        expect_val("ov_epc", 32'h0000_3020);
        expect_val("ov_cause", 32'h8000_0030);
        expect_val("ov_sr", 32'h0000_0403);
        tick;
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);
        checkOutput(epc_out);
        observe_reg(CP0_CAUSE);
        observe_reg(CP0_SR);

        // EXL=1 blocks both sources; IP still follows the line
        applyStimulus(1'b0, 5'd0, 32'd0, 32'h0000_3030, 1'b0, EXC_RI, 1'b0, 6'b000001);
        expect_val("exl_block_req", 32'd0);   observe_req;
        expect_val("exl_hold_epc", 32'h0000_3020);
        expect_val("exl_hold_cause", 32'h8000_0430);
        expect_val("exl_hold_sr", 32'h0000_0403);
        tick;
        checkOutput(epc_out);
        observe_reg(CP0_CAUSE);
        observe_reg(CP0_SR);

        // eret with the interrupt pending, then it fires the next cycle
        applyStimulus(1'b0, 5'd0, 32'd0, 32'h0000_3030, 1'b0, 5'd0, 1'b1, 6'b000001);
        expect_val("pending_eret_req", 32'd0); observe_req;
        expect_val("pending_eret_sr", 32'h0000_0401);
        tick;
        applyStimulus(1'b0, 5'd0, 32'd0, 32'h0000_3040, 1'b0, 5'd0, 1'b0, 6'b000001);
        observe_reg(CP0_SR);
        expect_val("pending_int_req", 32'd1); observe_req;
        expect_val("pending_epc", 32'h0000_3040);
        expect_val("pending_cause", 32'h0000_0400);
        expect_val("pending_sr", 32'h0000_0403);
        tick;
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);
        checkOutput(epc_out);
        observe_reg(CP0_CAUSE);
        observe_reg(CP0_SR);

        // request and mtc0 EPC in the same cycle: the write is dropped
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b1, 6'd0);
        tick;
        applyStimulus(1'b1, CP0_EPC, 32'hDEAD_BEEF, 32'h0000_3050, 1'b0, EXC_SYSCALL, 1'b0, 6'd0);
        expect_val("sys_req", 32'd1);         observe_req;
        expect_val("sys_epc", 32'h0000_3050);
        expect_val("sys_cause", 32'h0000_0020);
        expect_val("sys_sr", 32'h0000_0403);
        tick;
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);
        checkOutput(epc_out);
        observe_reg(CP0_CAUSE);
        observe_reg(CP0_SR);

        // writes to Cause and to an unmapped index are ignored
        applyStimulus(1'b1, CP0_CAUSE, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);
        tick;
        applyStimulus(1'b1, 5'd7, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);
        expect_val("ign_cause", 32'h0000_0020);
        expect_val("ign_sr", 32'h0000_0403);
        expect_val("ign_epc", 32'h0000_3050);
        expect_val("ign_addr7", 32'd0);
        tick;
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);
        observe_reg(CP0_CAUSE);
        observe_reg(CP0_SR);
        observe_reg(CP0_EPC);
        observe_reg(5'd7);

        // interrupt beats a simultaneous address-error exception
        applyStimulus(1'b1, CP0_SR, 32'h0000_8001, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);
        expect_val("prio_sr_write", 32'h0000_8001);
        tick;
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);
        observe_reg(CP0_SR);
        applyStimulus(1'b0, 5'd0, 32'd0, 32'h0000_3060, 1'b0, EXC_ADEL, 1'b0, 6'b100000);
        expect_val("prio_req", 32'd1);        observe_req;
        expect_val("prio_cause", 32'h0000_8000);
        expect_val("prio_epc", 32'h0000_3060);
        expect_val("prio_sr", 32'h0000_8003);
        tick;
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);
        observe_reg(CP0_CAUSE);
        checkOutput(epc_out);
        observe_reg(CP0_SR);

        // SR write together with eret: written fields land, EXL forced low
        applyStimulus(1'b1, CP0_SR, 32'h0000_0403, 32'd0, 1'b0, 5'd0, 1'b1, 6'd0);
        expect_val("clr_with_write_sr", 32'h0000_0401);
        tick;
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);
        observe_reg(CP0_SR);

        // unaligned victim PC outside a delay slot
        applyStimulus(1'b0, 5'd0, 32'd0, 32'h0000_3073, 1'b0, EXC_ADEL, 1'b0, 6'd0);
        expect_val("adel_req", 32'd1);        observe_req;
        expect_val("adel_epc", 32'h0000_3070);
        expect_val("adel_cause", 32'h0000_0010);
        tick;
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);
        checkOutput(epc_out);
        observe_reg(CP0_CAUSE);

        // full-width mtc0 EPC
        applyStimulus(1'b1, CP0_EPC, 32'h1234_5679, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);
        expect_val("mtc0_epc_out", 32'h1234_5679);
        expect_val("mtc0_epc_read", 32'h1234_5679);
        tick;
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);
        checkOutput(epc_out);
        observe_reg(CP0_EPC);

        // reset again with a line asserted: IP is forced to 0, IE=0 so no request
        applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 6'b000001);
        reset = 1'b1;
        expect_val("rst2_cause", 32'd0);
        expect_val("rst2_sr", 32'd0);
        expect_val("rst2_epc", 32'd0);
        expect_val("rst2_req", 32'd0);
        tick;
        reset = 1'b0;
        observe_reg(CP0_CAUSE);
        observe_reg(CP0_SR);
        observe_reg(CP0_EPC);
        observe_req;

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
